scaler_v_line_sched: RTL and testbench

//  Line-level scheduler for the vertical scaler. It owns the ring of NUM_BUF input line buffers.
//  It generates write select/address for incoming pixels and tracks which input lines are

---
 rtl/scaler_v_line_sched.sv | 152 +++++++++++++++
 tb/tb_scaler_v_line_sched.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/scaler_v_line_sched.sv
// scaler_v_line_sched: line scheduler for the vertical scaler input line-buffer ring
// Inputs:  clk, rst_n, frame parameters (scale_step, line_in_size, frame_in_lines), video in_de/in_hs/in_vs
// Outputs: in_ready throttle, write port (wr_sel/wr_addr/wr_en), read port (rd_sel0/rd_sel1/dy/rd_addr/rd_en),
//          early output timing (out_hs_early/out_vs_early), sticky overrun flag err_ovf
module scaler_v_line_sched #(
  parameter int NUM_BUF    = 3,
  parameter int LINE_STEP  = 4096,
  parameter int FRAC_WIDTH = 10,
  parameter int SPARSE_OUT = 2,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [15:0]           scale_step,
  input  logic [15:0]           line_in_size,
  input  logic [15:0]           frame_in_lines,
  input  logic                  in_de,
  input  logic                  in_hs,
  input  logic                  in_vs,
  output logic                  in_ready,
  output logic [1:0]            wr_sel,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic                  wr_en,
  output logic [1:0]            rd_sel0,
  output logic [1:0]            rd_sel1,
  output logic [FRAC_WIDTH-1:0] dy,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  rd_en,
  output logic                  out_hs_early,
  output logic                  out_vs_early,
  output logic                  err_ovf
);
  localparam int LSTEP_W = $clog2(LINE_STEP);
  typedef enum logic [1:0] {IDLE, PRM, READ, DONE} state_t;
  state_t state, state_d;
  logic [23:0] pos, prm_step;
  logic [15:0] prm_size, prm_lines, lines_wr, idx, idx_trk, size_eff, pix_addr;
  logic [1:0] lw_mod, idx_mod;
  logic [ADDR_WIDTH-1:0] rd_cnt;
  logic [7:0] cnt_sparse;
  logic frame_start, line_start, pix_last, caught, strobe, last;

  function automatic logic [1:0] nxt(input logic [1:0] v);
    return (int'(v) == NUM_BUF - 1) ? 2'd0 : v + 2'd1;
  endfunction

  assign frame_start = in_de & in_vs;
  assign line_start  = in_de & in_hs;
  assign idx         = 16'(pos >> LSTEP_W);
  // idx_trk/idx_mod follow idx one line per cycle so the ring index never needs a divider;
  // a line is only scheduled once the tracker has caught up with a possibly multi-line jump of pos
  assign caught      = idx_trk == idx;
  assign size_eff    = frame_start ? line_in_size : prm_size;
  assign pix_addr    = line_start ? 16'd0 : 16'(wr_addr) + 16'd1;
  assign pix_last    = in_de && pix_addr == size_eff - 16'd1;

  always_comb begin
    state_d = state;
    strobe  = 1'b0;
    last    = 1'b0;
    case (state)
      IDLE: if (caught) state_d = ({1'b0, idx} + 17'd1 >= {1'b0, prm_lines}) ? DONE :
                                  ({1'b0, lines_wr} >= {1'b0, idx} + 17'd2) ? PRM : IDLE;
      PRM:  state_d = READ;
      READ: begin
        strobe = cnt_sparse == 8'(SPARSE_OUT);
        last   = strobe && 16'(rd_cnt) == prm_size - 16'd1;
        if (last) state_d = IDLE;
      end
      DONE: state_d = DONE;
      default: state_d = IDLE;
    endcase
    if (frame_start) state_d = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready     <= 1'b1;
      wr_sel       <= '0;
      wr_addr      <= '0;
      wr_en        <= 1'b0;
      rd_sel0      <= '0;
      rd_sel1      <= '0;
      dy           <= '0;
      rd_addr      <= '0;
      rd_en        <= 1'b0;
      out_hs_early <= 1'b0;
      out_vs_early <= 1'b0;
      err_ovf      <= 1'b0;
      pos          <= '0;
      prm_step     <= '0;
      prm_size     <= '0;
      prm_lines    <= '0;
      lines_wr     <= '0;
      lw_mod       <= '0;
      idx_trk      <= '0;
      idx_mod      <= '0;
      rd_cnt       <= '0;
      cnt_sparse   <= '0;
    end else begin
      wr_en <= in_de;
      if (line_start) begin
        wr_addr <= '0;
        wr_sel  <= frame_start ? 2'd0 : lw_mod;
      end else if (in_de) wr_addr <= wr_addr + 1'b1;
      if (frame_start) begin
        lines_wr  <= {15'd0, pix_last};
        lw_mod    <= pix_last ? nxt(2'd0) : 2'd0;
        pos       <= '0;
        idx_trk   <= '0;
        idx_mod   <= '0;
        err_ovf   <= 1'b0;
        prm_step  <= (scale_step == 16'd0) ? 24'(LINE_STEP) : 24'(scale_step);
        prm_size  <= line_in_size;
        prm_lines <= frame_in_lines;
      end else begin
        if (pix_last) begin
          lines_wr <= lines_wr + 16'd1;
          lw_mod   <= nxt(lw_mod);
        end
        if (line_start && !in_ready) err_ovf <= 1'b1;
        if (last) pos <= pos + prm_step;
        if (!caught) begin
          idx_trk <= idx_trk + 16'd1;
          idx_mod <= nxt(idx_mod);
        end
      end
      // lines below idx are no longer needed, so a reader that skipped ahead never blocks the source
      in_ready     <= lines_wr < idx || (lines_wr - idx) < 16'(NUM_BUF);
      rd_en        <= strobe & ~frame_start;
      out_hs_early <= strobe & ~frame_start & (rd_cnt == '0);
      out_vs_early <= strobe & ~frame_start & (rd_cnt == '0) & (pos == '0);
      if (state == PRM) begin
        rd_sel0    <= idx_mod;
        rd_sel1    <= nxt(idx_mod);
        dy         <= pos[LSTEP_W-1 -: FRAC_WIDTH];
        rd_cnt     <= '0;
        cnt_sparse <= '0;
      end else if (state == READ) begin
        cnt_sparse <= strobe ? 8'd0 : cnt_sparse + 8'd1;
        if (strobe) begin
          rd_addr <= rd_cnt;
          rd_cnt  <= rd_cnt + 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_scaler_v_line_sched.sv
// tb_scaler_v_line_sched: randomized self-checking bench for scaler_v_line_sched
module tb_scaler_v_line_sched;
  localparam int SP = 2;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [15:0] scale_step = '0, line_in_size = '0, frame_in_lines = '0;
  logic in_de = 1'b0, in_hs = 1'b0, in_vs = 1'b0;
  logic in_ready, wr_en, rd_en, out_hs_early, out_vs_early, err_ovf;
  logic [1:0] wr_sel, rd_sel0, rd_sel1;
  logic [9:0] wr_addr, rd_addr, dy;

  scaler_v_line_sched dut (
    .clk(clk), .rst_n(rst_n), .scale_step(scale_step), .line_in_size(line_in_size),
    .frame_in_lines(frame_in_lines), .in_de(in_de), .in_hs(in_hs), .in_vs(in_vs),
    .in_ready(in_ready), .wr_sel(wr_sel), .wr_addr(wr_addr), .wr_en(wr_en),
    .rd_sel0(rd_sel0), .rd_sel1(rd_sel1), .dy(dy), .rd_addr(rd_addr), .rd_en(rd_en),
    .out_hs_early(out_hs_early), .out_vs_early(out_vs_early), .err_ovf(err_ovf)
  );

  always #5 clk = ~clk;

  typedef struct {int cyc; logic [25:0] pk; int started; int done;} rd_rec_t;
  typedef struct {int idx; logic [1:0] s0; logic [1:0] s1; logic [9:0] dy; bit vs;} ln_t;
  rd_rec_t rd_q[$];
  logic [11:0] wr_q[$], exp_wr[$];
  ln_t exp_ln[$];
  rd_rec_t mon_r;
  int cyc = 0, started = 0, done = 0, n_tests = 0, n_fail = 0;
  bit tmo, saw_wait;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (wr_en) wr_q.push_back({wr_sel, wr_addr});
    if (rd_en) begin
      mon_r.cyc = cyc;
      mon_r.pk = {rd_sel0, rd_sel1, dy, rd_addr, out_hs_early, out_vs_early};
      mon_r.started = started;
      mon_r.done = done;
      rd_q.push_back(mon_r);
    end
  end

  // output lines a frame must produce: one per pitch step while a lower source line still exists
  task automatic model(input int step, input int lines);
    ln_t ln;
    int p = 0;
    exp_ln.delete();
    if (step == 0) step = 4096;
    while (p / 4096 + 1 < lines) begin
      ln.idx = p / 4096;
      ln.s0 = 2'((p / 4096) % 3);
      ln.s1 = 2'((p / 4096 + 1) % 3);
      ln.dy = 10'((p % 4096) / 4);
      ln.vs = (p == 0);
      exp_ln.push_back(ln);
      p += step;
    end
  endtask

  task automatic drive_frame(input int size, input int nsend, input bit ign, input int step, input int lines);
    started = 0;
    done = 0;
    for (int l = 0; l < nsend; l++) begin
      if (l > 0) begin
        int t = 0;
        repeat (ign ? 2 : 2 + $urandom_range(0, 2)) begin
          @(negedge clk);
          in_de = 0; in_hs = 0; in_vs = 0;
        end
        while (!ign && !in_ready && t < 3000) begin
          saw_wait = 1;
          @(negedge clk);
          t++;
        end
        if (!ign && !in_ready) tmo = 1;
      end
      for (int p = 0; p < size; p++) begin
        @(negedge clk);
        if (l == 0 && p == 0) begin
          scale_step = 16'(step); line_in_size = 16'(size); frame_in_lines = 16'(lines);
        end
        in_de = 1; in_hs = (p == 0); in_vs = (p == 0 && l == 0);
        exp_wr.push_back({2'(l % 3), 10'(p)});
        if (p == 0) started++;
        if (p == size - 1) done++;
        if (!ign && p < size - 1 && $urandom_range(0, 3) == 0) begin
          @(negedge clk);
          in_de = 0; in_hs = 0; in_vs = 0;
        end
      end
    end
    @(negedge clk);
    in_de = 0; in_hs = 0; in_vs = 0;
  endtask

  task automatic wait_out(input int n);
    int t = 0;
    while (rd_q.size() < n && t < 5000) begin
      @(negedge clk);
      t++;
    end
    if (rd_q.size() < n) tmo = 1;
    repeat (30) @(negedge clk);
  endtask

  task automatic test_reset;
    logic [41:0] o;
    repeat (2) @(negedge clk);
    o = {in_ready, wr_sel, wr_addr, wr_en, rd_sel0, rd_sel1, dy, rd_addr, rd_en, out_hs_early, out_vs_early, err_ovf};
    n_tests++;
    if (o !== {1'b1, 41'd0}) begin n_fail++; $display("FAIL reset_state got=%h exp=%h", o, {1'b1, 41'd0}); end
    rst_n = 1;
    repeat (3) @(negedge clk);
    o = {in_ready, wr_sel, wr_addr, wr_en, rd_sel0, rd_sel1, dy, rd_addr, rd_en, out_hs_early, out_vs_early, err_ovf};
    n_tests++;
    if (o !== {1'b1, 41'd0}) begin n_fail++; $display("FAIL after_reset got=%h exp=%h", o, {1'b1, 41'd0}); end
  endtask

  task automatic test_scaling;
    int ts[7] = '{4096, 2048, 8192, 0, 4096, 3000, -1};
    int tz[7] = '{8, 8, 8, 5, 1, 6, -1};
    int tl[7] = '{4, 4, 6, 3, 2, 5, -1};
    for (int c = 0; c < 7; c++) begin
      int step = ts[c], size = tz[c], lines = tl[c], n;
      logic [25:0] e;
      if (step < 0) begin
        step = $urandom_range(1024, 12000); size = $urandom_range(1, 12); lines = $urandom_range(2, 7);
      end
      rd_q.delete(); wr_q.delete(); exp_wr.delete(); tmo = 0; saw_wait = 0;
      model(step, lines);
      n = exp_ln.size() * size;
      drive_frame(size, lines, 0, step, lines);
      wait_out(n);
      n_tests++;
      if (tmo !== 0) begin n_fail++; $display("FAIL cfg%0d timeout got=%0d exp=0", c, tmo); end
      n_tests++;
      if (rd_q.size() != n) begin n_fail++; $display("FAIL cfg%0d strobe_count got=%0d exp=%0d", c, rd_q.size(), n); end
      for (int j = 0; j < n && j < rd_q.size(); j++) begin
        int k = j / size, a = j % size;
        e = {exp_ln[k].s0, exp_ln[k].s1, exp_ln[k].dy, 10'(a), 1'(a == 0), 1'(a == 0 && exp_ln[k].vs)};
        n_tests++;
        if (rd_q[j].pk !== e) begin n_fail++; $display("FAIL cfg%0d strobe%0d sel0,sel1,dy,addr,hs,vs got=%h exp=%h", c, j, rd_q[j].pk, e); end
        if (a > 0) begin
          n_tests++;
          if (rd_q[j].cyc - rd_q[j-1].cyc != SP + 1) begin
            n_fail++; $display("FAIL cfg%0d spacing%0d got=%0d exp=%0d", c, j, rd_q[j].cyc - rd_q[j-1].cyc, SP + 1);
          end
        end
        n_tests++;
        if (rd_q[j].done < exp_ln[k].idx + 2 || rd_q[j].started > exp_ln[k].idx + 3) begin
          n_fail++; $display("FAIL cfg%0d line_guard%0d got done=%0d started=%0d exp idx=%0d", c, j, rd_q[j].done, rd_q[j].started, exp_ln[k].idx);
        end
      end
      n_tests++;
      if (wr_q.size() != exp_wr.size()) begin n_fail++; $display("FAIL cfg%0d write_count got=%0d exp=%0d", c, wr_q.size(), exp_wr.size()); end
      for (int j = 0; j < wr_q.size() && j < exp_wr.size(); j++) begin
        n_tests++;
        if (wr_q[j] !== exp_wr[j]) begin n_fail++; $display("FAIL cfg%0d write%0d sel,addr got=%h exp=%h", c, j, wr_q[j], exp_wr[j]); end
      end
      if (c == 2) begin
        n_tests++;
        if (saw_wait !== 1) begin n_fail++; $display("FAIL downscale_throttle got=%0d exp=1", saw_wait); end
      end
    end
  endtask

  task automatic test_overflow;
    rd_q.delete(); wr_q.delete(); exp_wr.delete(); tmo = 0;
    drive_frame(8, 6, 1, 4096, 6);
    n_tests++;
    if (err_ovf !== 1) begin n_fail++; $display("FAIL err_ovf_set got=%b exp=1", err_ovf); end
    exp_wr.delete();
    model(4096, 4);
    fork
      drive_frame(8, 4, 0, 4096, 4);
      begin
        @(negedge clk);
        #1;
        rd_q.delete(); wr_q.delete();
        @(negedge clk);
        n_tests++;
        if (err_ovf !== 0) begin n_fail++; $display("FAIL err_ovf_clear got=%b exp=0", err_ovf); end
      end
    join
    wait_out(24);
    n_tests++;
    if (rd_q.size() != 24) begin n_fail++; $display("FAIL ovf_next_count got=%0d exp=24", rd_q.size()); end
    n_tests++;
    if (rd_q.size() > 0 && rd_q[0].pk !== {2'd0, 2'd1, 10'd0, 10'd0, 1'b1, 1'b1}) begin
      n_fail++; $display("FAIL ovf_next_first got=%h exp=%h", rd_q[0].pk, {2'd0, 2'd1, 10'd0, 10'd0, 1'b1, 1'b1});
    end
    n_tests++;
    if (wr_q.size() > 0 && wr_q[0] !== 12'd0) begin n_fail++; $display("FAIL ovf_next_wr0 got=%h exp=0", wr_q[0]); end
    n_tests++;
    if (err_ovf !== 0 || tmo !== 0) begin n_fail++; $display("FAIL ovf_next_clean got err=%b tmo=%b exp 0 0", err_ovf, tmo); end
  endtask

  task automatic test_vs_during_read;
    int t = 0;
    rd_q.delete(); wr_q.delete(); exp_wr.delete(); tmo = 0;
    drive_frame(8, 2, 0, 4096, 4);
    while (rd_en !== 1 && t < 500) begin @(negedge clk); t++; end
    n_tests++;
    if (rd_en !== 1) begin n_fail++; $display("FAIL vs_first_strobe got=%b exp=1", rd_en); end
    @(negedge clk);
    exp_wr.delete();
    model(2048, 4);
    fork
      drive_frame(8, 4, 0, 2048, 4);
      begin
        @(negedge clk);
        #1;
        rd_q.delete(); wr_q.delete();
        @(negedge clk);
        n_tests++;
        if (rd_en !== 0) begin n_fail++; $display("FAIL vs_abort_rd_en got=%b exp=0", rd_en); end
      end
    join
    wait_out(48);
    n_tests++;
    if (rd_q.size() != 48 || tmo !== 0) begin n_fail++; $display("FAIL vs_new_count got=%0d exp=48", rd_q.size()); end
    if (rd_q.size() == 48) begin
      n_tests++;
      if (rd_q[0].pk !== {2'd0, 2'd1, 10'd0, 10'd0, 1'b1, 1'b1}) begin
        n_fail++; $display("FAIL vs_new_first got=%h exp=%h", rd_q[0].pk, {2'd0, 2'd1, 10'd0, 10'd0, 1'b1, 1'b1});
      end
      n_tests++;
      if (rd_q[8].pk !== {2'd0, 2'd1, 10'd512, 10'd0, 1'b1, 1'b0}) begin
        n_fail++; $display("FAIL vs_new_line1 got=%h exp=%h", rd_q[8].pk, {2'd0, 2'd1, 10'd512, 10'd0, 1'b1, 1'b0});
      end
      n_tests++;
      if (rd_q[47].pk !== {2'd2, 2'd0, 10'd512, 10'd7, 1'b0, 1'b0}) begin
        n_fail++; $display("FAIL vs_new_last got=%h exp=%h", rd_q[47].pk, {2'd2, 2'd0, 10'd512, 10'd7, 1'b0, 1'b0});
      end
    end
  endtask

  task automatic test_reset_mid_read;
    int t = 0;
    logic [41:0] o;
    drive_frame(8, 2, 0, 4096, 4);
    while (rd_en !== 1 && t < 500) begin @(negedge clk); t++; end
    n_tests++;
    if (rd_en !== 1) begin n_fail++; $display("FAIL mid_read_strobe got=%b exp=1", rd_en); end
    @(negedge clk);
    rst_n = 0;
    @(negedge clk);
    o = {in_ready, wr_sel, wr_addr, wr_en, rd_sel0, rd_sel1, dy, rd_addr, rd_en, out_hs_early, out_vs_early, err_ovf};
    n_tests++;
    if (o !== {1'b1, 41'd0}) begin n_fail++; $display("FAIL mid_read_reset got=%h exp=%h", o, {1'b1, 41'd0}); end
    rst_n = 1;
    repeat (4) @(negedge clk);
    o = {in_ready, wr_sel, wr_addr, wr_en, rd_sel0, rd_sel1, dy, rd_addr, rd_en, out_hs_early, out_vs_early, err_ovf};
    n_tests++;
    if (o !== {1'b1, 41'd0}) begin n_fail++; $display("FAIL mid_read_release got=%h exp=%h", o, {1'b1, 41'd0}); end
  endtask

  initial begin
    #500000;
    n_tests++;
    n_fail++;
    $display("FAIL watchdog got=running exp=finished");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    test_reset();
    test_scaling();
    test_overflow();
    test_vs_during_read();
    test_reset_mid_read();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
